bin_a_bcd_secuencial: RTL and testbench
=======================================

# bin_a_bcd_secuencial

Sequential, parametrised binary-to-BCD converter that replaces the fixed 5-bit combinational converter in display paths needing wider values. It uses the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock. A start/ready/done handshake lets a producer such as an ALU or counter feed it, and the 7-segment decoders downstream read its registered BCD output.

## Interface
- N, default 8: binary input width; N ≥ 1.
- DIGITS, default 3: number of BCD digits; elaboration fails unless 10^DIGITS > 2^N − 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- bin  input  N  unsigned value; captured in the cycle start is accepted.
- ready  output  1  high when a new start will be accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse: bcd has just been updated.
- bcd  output  4*DIGITS  result; digit k occupies bits [4k+3:4k], with digit 0 as the units digit.

## Operation
- FSM states: INACTIVO, CONVIRTIENDO, LISTO.
- INACTIVO: ready=1, busy=0. On start=1, capture bin into shift register sh, clear the scratch BCD register acc, load bit counter cnt=N, and go to CONVIRTIENDO.
- CONVIRTIENDO: ready=0, busy=1. Each cycle:
  - Every acc digit ≥ 5 gets +3.
  - {acc, sh} shifts left by one bit.
  - cnt decrements.
  - When cnt reaches 1 (last shift performed this cycle), go to LISTO.
- LISTO: load bcd from the final acc value, so the loaded value includes the last shift. Assert done=1 for this cycle. ready=1, busy=0.
  - start=1 here is accepted exactly as in INACTIVO (back-to-back) and goes to CONVIRTIENDO. Otherwise go to INACTIVO.
- start while busy=1 is ignored; no queueing. bin is don't-care except in the accept cycle.
- bcd changes only in LISTO and never shows partial results. It holds its value until the next LISTO or reset.
- Arithmetic:
  - acc is 4*DIGITS bits wide.
  - The add-3 correction applies per digit to values 5..9. Digit values above 9 cannot occur given the DIGITS constraint.
  - The bit shifted out of the top of acc is always 0.
- Reset mid-operation: rst=1 in any state forces INACTIVO and aborts the conversion. rst has priority over start.

## Timing
- Reset values: ready=1, busy=0, done=0, bcd=0. sh, acc and cnt are cleared.
- Latency: start accepted at edge t, done=1 during the cycle after edge t+N, i.e. N+1 cycles from accept to done.
- Throughput: with start held high, one result every N+1 cycles.
- ready, busy and done are decoded from registered state with no combinational path from start. The only combinational dependence on start is the next-state logic.
- N=1 case: CONVIRTIENDO lasts exactly one cycle.

## Structure
- Package bcd_pkg holds:
  - the state enum estado_bcd_t (INACTIVO, CONVIRTIENDO, LISTO);
  - the function digitos_min(n), returning the smallest valid DIGITS, used by the elaboration check;
  - the constant BCD_AJUSTE = 4'd3.
- Sub-module bcd_digito_ajuste: combinational, 4-bit in/out, returns d+3 when d≥5 and d otherwise. Instantiated DIGITS times with a generate loop.
- Top level holds the FSM, sh, acc, cnt (width $clog2(N+1)) and the bcd register.

## Test plan
- N=5, DIGITS=2: bin=31, start pulse → done 6 cycles later; bcd=8'h31; ready high in the done cycle.
- N=8, DIGITS=3: sweep bin 0..255, one at a time → bcd equals a decimal reference model for every value (0 → 12'h000, 255 → 12'h255).
- N=8: start held high with bin=99, then 100 presented at the next accept → done pulses 9 cycles apart; bcd=12'h099, then 12'h100, with no idle cycle between.
- N=8: bin=200 accepted, then start=1 with bin=7 on the next 3 cycles → second request ignored; bcd=12'h200; busy stays high for 8 cycles.
- N=8: bin=255 accepted, rst=1 on the 4th conversion cycle → next cycle ready=1, busy=0, bcd=0, and no done pulse; a new conversion of 42 then gives 12'h042.
- Elaboration with N=10, DIGITS=3 → fails the DIGITS constraint; N=10, DIGITS=4 with bin=1023 → bcd=16'h1023.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type, digit-count helper and add-3 constant for the binary-to-BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {INACTIVO, CONVIRTIENDO, LISTO} estado_bcd_t;
  localparam logic [3:0] BCD_AJUSTE = 4'd3;
  function automatic int digitos_min(input int n);
    longint unsigned m;
    longint unsigned p;
    int d;
    m = (64'd1 << n) - 64'd1;
    p = 64'd10;
    d = 1;
    for (int i = 0; i < 20; i++)
      if (p <= m) begin
        p = p * 64'd10;
        d = d + 1;
      end
    return d;
  endfunction
endpackage

// File: rtl/bcd_digito_ajuste.sv
// bcd_digito_ajuste: double-dabble digit correction, d+3 when d>=5 else d (d: digit in, q: corrected digit out)
module bcd_digito_ajuste
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + BCD_AJUSTE : d;
endmodule

// File: rtl/bin_a_bcd_secuencial.sv
// bin_a_bcd_secuencial: one-bit-per-clock binary-to-BCD converter (clk, rst, start/bin in; ready, busy, done, bcd out)
module bin_a_bcd_secuencial
  import bcd_pkg::*;
#(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);
  if (DIGITS < digitos_min(N)) begin : g_chk
    $error("DIGITS too small to hold 2**N-1");
  end
  estado_bcd_t estado, estado_sig;
  logic [N-1:0]   sh;
  logic [W-1:0]   acc, acc_aj;
  logic [CW-1:0]  cnt;
  logic [W+N-1:0] desplazado;
  logic           aceptar, ultimo;
  for (genvar k = 0; k < DIGITS; k++) begin : g_aj
    bcd_digito_ajuste u_aj (.d(acc[4*k +: 4]), .q(acc_aj[4*k +: 4]));
  end
  // the bit leaving the top of acc is always 0, so truncating the shift is lossless
  assign desplazado = {acc_aj, sh} << 1;
  assign aceptar    = ready & start;
  assign ultimo     = (estado == CONVIRTIENDO) && (cnt == CW'(1));
  always_ff @(posedge clk)
    estado <= rst ? INACTIVO : estado_sig;
  always_comb begin
    estado_sig = estado;
    case (estado)
      INACTIVO:     estado_sig = start ? CONVIRTIENDO : INACTIVO;
      CONVIRTIENDO: estado_sig = ultimo ? LISTO : CONVIRTIENDO;
      LISTO:        estado_sig = start ? CONVIRTIENDO : INACTIVO;
      default:      estado_sig = INACTIVO;
    endcase
  end
  always_comb begin
    ready = estado != CONVIRTIENDO;
    busy  = estado == CONVIRTIENDO;
    done  = estado == LISTO;
  end
  // bcd is loaded on the edge entering LISTO so it is already valid while done is high
  always_ff @(posedge clk)
    if (rst) begin
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
      bcd <= '0;
    end else if (aceptar) begin
      sh  <= bin;
      acc <= '0;
      cnt <= CW'(N);
    end else if (estado == CONVIRTIENDO) begin
      {acc, sh} <= desplazado;
      cnt       <= cnt - 1'b1;
      if (ultimo) bcd <= desplazado[W+N-1:N];
    end
endmodule

// File: tb/tb_bin_a_bcd_secuencial.sv
// tb_bin_a_bcd_secuencial: directed, table-driven check of the sequential binary-to-BCD converter
module tb_bin_a_bcd_secuencial;
  import bcd_pkg::*;
  logic clk = 0, rst = 1;
  logic s8 = 0, s5 = 0, s10 = 0, s1 = 0;
  logic [7:0] b8 = 0;
  logic [4:0] b5 = 0;
  logic [9:0] b10 = 0;
  logic [0:0] b1 = 0;
  logic r8, y8, d8, r5, y5, d5, r10, y10, d10, r1, y1, d1;
  logic [11:0] q8;
  logic [7:0]  q5;
  logic [15:0] q10;
  logic [3:0]  q1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  bin_a_bcd_secuencial #(.N(8), .DIGITS(3)) u8 (.clk(clk), .rst(rst), .start(s8), .bin(b8),
    .ready(r8), .busy(y8), .done(d8), .bcd(q8));
  bin_a_bcd_secuencial #(.N(5), .DIGITS(2)) u5 (.clk(clk), .rst(rst), .start(s5), .bin(b5),
    .ready(r5), .busy(y5), .done(d5), .bcd(q5));
  bin_a_bcd_secuencial #(.N(10), .DIGITS(4)) u10 (.clk(clk), .rst(rst), .start(s10), .bin(b10),
    .ready(r10), .busy(y10), .done(d10), .bcd(q10));
  bin_a_bcd_secuencial #(.N(1), .DIGITS(1)) u1 (.clk(clk), .rst(rst), .start(s1), .bin(b1),
    .ready(r1), .busy(y1), .done(d1), .bcd(q1));
  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  task automatic conv8(input logic [7:0] v, output int lat);
    @(negedge clk); s8 = 1; b8 = v;
    @(negedge clk); s8 = 0; b8 = 8'hxx;
    lat = 1;
    while (!d8 && lat < 40) begin @(negedge clk); lat++; end
  endtask
  initial begin
    int lat, k, bc;
    tbl[0]  = '{8'd0,   12'h000};
    tbl[1]  = '{8'd1,   12'h001};
    tbl[2]  = '{8'd9,   12'h009};
    tbl[3]  = '{8'd10,  12'h010};
    tbl[4]  = '{8'd42,  12'h042};
    tbl[5]  = '{8'd59,  12'h059};
    tbl[6]  = '{8'd99,  12'h099};
    tbl[7]  = '{8'd100, 12'h100};
    tbl[8]  = '{8'd128, 12'h128};
    tbl[9]  = '{8'd199, 12'h199};
    tbl[10] = '{8'd200, 12'h200};
    tbl[11] = '{8'd255, 12'h255};
    chk("digitos_min(1)", digitos_min(1), 1);
    chk("digitos_min(5)", digitos_min(5), 2);
    chk("digitos_min(8)", digitos_min(8), 3);
    chk("digitos_min(10)", digitos_min(10), 4);
    repeat (2) @(negedge clk);
    chk("rst ready", r8, 1); chk("rst busy", y8, 0);
    chk("rst done", d8, 0);  chk("rst bcd", q8, 0);
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      conv8(tbl[i].bin, lat);
      chk($sformatf("tbl bcd bin=%0d", tbl[i].bin), q8, tbl[i].bcd);
      chk($sformatf("tbl latency bin=%0d", tbl[i].bin), lat, 9);
    end
    for (int v = 0; v < 256; v++) begin
      conv8(8'(v), lat);
      chk($sformatf("sweep bin=%0d", v), q8, ref_bcd(v));
    end
    @(negedge clk); s5 = 1; b5 = 5'd31;
    @(negedge clk); s5 = 0;
    lat = 1;
    while (!d5 && lat < 40) begin @(negedge clk); lat++; end
    chk("n5 latency", lat, 6); chk("n5 bcd", q5, 8'h31); chk("n5 ready at done", r5, 1);
    @(negedge clk); s10 = 1; b10 = 10'd1023;
    @(negedge clk); s10 = 0;
    lat = 1;
    while (!d10 && lat < 40) begin @(negedge clk); lat++; end
    chk("n10 latency", lat, 11); chk("n10 bcd", q10, 16'h1023);
    @(negedge clk); s1 = 1; b1 = 1'b1;
    @(negedge clk); s1 = 0;
    chk("n1 busy", y1, 1);
    @(negedge clk);
    chk("n1 done", d1, 1); chk("n1 bcd", q1, 4'h1);
    @(negedge clk); s8 = 1; b8 = 8'd99;
    @(negedge clk); b8 = 8'd100;
    k = 0;
    while (!d8 && k < 40) begin @(negedge clk); k++; end
    chk("b2b first bcd", q8, 12'h099); chk("b2b ready in done", r8, 1);
    k = 0;
    do begin @(negedge clk); k++; end while (!d8 && k < 40);
    s8 = 0;
    chk("b2b spacing", k, 9); chk("b2b second bcd", q8, 12'h100);
    @(negedge clk);
    chk("b2b stops", y8, 0);
    @(negedge clk); s8 = 1; b8 = 8'd200;
    @(negedge clk); b8 = 8'd7;
    bc = 0; k = 0;
    while (!d8 && k < 40) begin
      if (y8) bc++;
      @(negedge clk); k++;
      if (k == 3) s8 = 0;
    end
    chk("ignore busy cycles", bc, 8); chk("ignore bcd", q8, 12'h200);
    @(negedge clk);
    chk("ignore no requeue", y8, 0);
    @(negedge clk); s8 = 1; b8 = 8'd255;
    @(negedge clk); s8 = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort ready", r8, 1); chk("abort busy", y8, 0);
    chk("abort bcd", q8, 0);   chk("abort done", d8, 0);
    rst = 0;
    k = 0;
    repeat (12) begin @(negedge clk); if (d8) k++; end
    chk("abort no done", k, 0);
    conv8(8'd42, lat);
    chk("after abort bcd", q8, 12'h042); chk("after abort latency", lat, 9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
